// File: rtl/vending_machine_param.sv
// -----------------------------------------------------------------------------
// vending_machine_param
//
// Parametrised vending controller. It accepts 5, 10 and 20 rs coins against a
// configurable price and vends as soon as the stored credit covers the price.
// Change, or the refund of a cancelled purchase, is paid out one coin per
// cycle, 10 rs coins first. All outputs are registered.
//
// Parameters
//   PRICE  product price in 5-rs units (1 .. 2^CW-4)
//   CW     credit register width in 5-rs units (must hold PRICE-1+4)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous, active-high reset
//   coin[1:0]    coin presented: 00 none, 01 5 rs, 10 10 rs, 11 20 rs
//   cancel       level request to refund the current credit
//   vend         one-cycle pulse releasing one product
//   change[1:0]  coin dispensed this cycle: 00 none, 01 5 rs, 10 10 rs
//   busy         high while paying out; coin gate closed
//   coin_reject  one-cycle pulse, a coin presented while busy is returned
//   credit       current stored credit in 5-rs units
// -----------------------------------------------------------------------------
module vending_machine_param #(
    parameter int PRICE = 3,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    coin,
    input  logic          cancel,
    output logic          vend,
    output logic [1:0]    change,
    output logic          busy,
    output logic          coin_reject,
    output logic [CW-1:0] credit
);

    typedef enum logic {
        COLLECT  = 1'b0,
        DISPENSE = 1'b1
    } state_t;

    localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);

    // Coin code to value in 5-rs units; the 20 rs coin is worth 4, not 3.
    function automatic logic [CW:0] coin_value(input logic [1:0] c);
        logic [CW:0] v;
        case (c)
            2'b01:   v = (CW+1)'(1);
            2'b10:   v = (CW+1)'(2);
            2'b11:   v = (CW+1)'(4);
            default: v = '0;
        endcase
        return v;
    endfunction

    state_t        r_state;
    logic          r_vend;
    logic [1:0]    r_change;
    logic          r_coin_reject;
    logic [CW-1:0] r_credit;

    // One bit wider than the credit so the price comparison is exact.
    logic [CW:0]   w_sum;

    assign w_sum = {1'b0, r_credit} + coin_value(coin);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= COLLECT;
            r_vend        <= 1'b0;
            r_change      <= 2'b00;
            r_coin_reject <= 1'b0;
            r_credit      <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    r_change      <= 2'b00;
                    r_coin_reject <= 1'b0;
                    r_vend        <= 1'b0;
                    if (w_sum >= PRICE_W) begin
                        // Purchase completes; cancel loses to the vend.
                        r_vend   <= 1'b1;
                        r_credit <= CW'(w_sum - PRICE_W);
                        if (w_sum != PRICE_W) begin
                            r_state <= DISPENSE;
                        end
                    end else if (cancel && (w_sum != '0)) begin
                        // Refund everything, including a coin landing now.
                        r_credit <= w_sum[CW-1:0];
                        r_state  <= DISPENSE;
                    end else begin
                        r_credit <= w_sum[CW-1:0];
                    end
                end

                DISPENSE: begin
                    r_vend        <= 1'b0;
                    r_coin_reject <= (coin != 2'b00);
                    if (r_credit >= CW'(2)) begin
                        r_change <= 2'b10;
                        r_credit <= r_credit - CW'(2);
                        if (r_credit == CW'(2)) begin
                            r_state <= COLLECT;
                        end
                    end else if (r_credit == CW'(1)) begin
                        r_change <= 2'b01;
                        r_credit <= '0;
                        r_state  <= COLLECT;
                    end else begin
                        // Defensive: nothing left to pay.
                        r_change <= 2'b00;
                        r_state  <= COLLECT;
                    end
                end

                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    assign vend        = r_vend;
    assign change      = r_change;
    assign busy        = (r_state == DISPENSE);
    assign coin_reject = r_coin_reject;
    assign credit      = r_credit;

endmodule
